// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU operation codes, stage occupancy encodings and the entry layout
// that the execute stage holds in its output and skid registers.
package alu_exec_stage_pkg;

    localparam logic [3:0] ALU_ADD    = 4'h0;
    localparam logic [3:0] ALU_SUB    = 4'h1;
    localparam logic [3:0] ALU_SLL    = 4'h2;
    localparam logic [3:0] ALU_SRL    = 4'h3;
    localparam logic [3:0] ALU_SRA    = 4'h4;
    localparam logic [3:0] ALU_SLT    = 4'h5;
    localparam logic [3:0] ALU_SLTU   = 4'h6;
    localparam logic [3:0] ALU_XOR    = 4'h7;
    localparam logic [3:0] ALU_OR     = 4'h8;
    localparam logic [3:0] ALU_AND    = 4'h9;
    localparam logic [3:0] ALU_COPY_B = 4'hA;
    localparam logic [3:0] ALU_XXX    = 4'hF;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
    } entry_t;

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// Purely combinational ALU; any code outside the defined set yields zero and
// raises illegal.
module alu_core
    import alu_exec_stage_pkg::*;
(
    input  logic [3:0]  aluop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        illegal
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result  = 32'd0;
        illegal = 1'b0;
        case (aluop)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << shamt;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:   result = {31'd0, a < b};
            ALU_XOR:    result = a ^ b;
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_COPY_B: result = b;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: one-cycle ALU with a two-entry output/skid buffer so that
// in_ready is a pure function of registered state.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_aluop,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_rd,
    input  logic        in_we,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal
);

    logic [1:0]  state_q, state_d;
    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    entry_t      in_entry;
    logic [31:0] alu_result;
    logic        alu_illegal;
    logic        accept;
    logic        drain;

    alu_core u_alu_core (
        .aluop   (in_aluop),
        .a       (in_a),
        .b       (in_b),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    assign in_entry = '{result: alu_result, rd: in_rd, we: in_we, illegal: alu_illegal};

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over any same-edge accept.
            state_d = ST_EMPTY;
            out_d   = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_d   = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = ST_TWO;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign out_result  = out_q.result;
    assign out_rd      = out_q.rd;
    assign out_we      = out_q.we;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage: ALU ops, streaming,
// backpressure, flush and asynchronous reset.
module tb_alu_exec_stage;
    import alu_exec_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_aluop;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_aluop    (in_aluop),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rd       (in_rd),
        .in_we       (in_we),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_illegal (out_illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic we);
        in_valid = 1'b1;
        in_aluop = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        in_we    = we;
        $display("txn op=%0h a=%08h b=%08h rd=%0d we=%0d", op, a, b, rd, we);
    endtask

    // Streamed vector: drive, clock once, expect the result on the very next cycle.
    task automatic vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic we,
                       input logic [31:0] exp, input logic ill);
        drive(op, a, b, rd, we);
        step();
        check_eq({tag, "_valid"},   {31'd0, out_valid},   32'd1);
        check_eq({tag, "_result"},  out_result,           exp);
        check_eq({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, ill});
        check_eq({tag, "_rd"},      {27'd0, out_rd},      {27'd0, rd});
        check_eq({tag, "_we"},      {31'd0, out_we},      {31'd0, we});
        check_eq({tag, "_inrdy"},   {31'd0, in_ready},    32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_aluop  = ALU_ADD;
        in_a      = '0;
        in_b      = '0;
        in_rd     = '0;
        in_we     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;

        #12;
        check_eq("rst_valid",  {31'd0, out_valid}, 32'd0);
        check_eq("rst_inrdy",  {31'd0, in_ready},  32'd1);
        check_eq("rst_result", out_result,         32'd0);
        check_eq("rst_rdwe",   {26'd0, out_rd, out_we}, 32'd0);
        check_eq("rst_ill",    {31'd0, out_illegal}, 32'd0);
        reset_n = 1'b1;
        step();

        // Streaming at one op per cycle with out_ready held high.
        vec("add",  ALU_ADD,    32'hFFFF_FFFF, 32'h0000_0001, 5'd1,  1'b1, 32'h0000_0000, 1'b0);
        vec("sub",  ALU_SUB,    32'h0000_0000, 32'h0000_0001, 5'd2,  1'b0, 32'hFFFF_FFFF, 1'b0);
        vec("sll",  ALU_SLL,    32'h0000_0001, 32'h0000_0021, 5'd3,  1'b1, 32'h0000_0002, 1'b0);
        vec("srl",  ALU_SRL,    32'h8000_0000, 32'h0000_001F, 5'd4,  1'b0, 32'h0000_0001, 1'b0);
        vec("sra",  ALU_SRA,    32'h8000_0000, 32'h0000_0024, 5'd6,  1'b1, 32'hF800_0000, 1'b0);
        vec("slt",  ALU_SLT,    32'hFFFF_FFFF, 32'h0000_0000, 5'd7,  1'b1, 32'h0000_0001, 1'b0);
        vec("sltu", ALU_SLTU,   32'hFFFF_FFFF, 32'h0000_0000, 5'd8,  1'b0, 32'h0000_0000, 1'b0);
        vec("xor",  ALU_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9,  1'b1, 32'h0FF0_0FF0, 1'b0);
        vec("or",   ALU_OR,     32'hF0F0_F0F0, 32'h0F00_0000, 5'd10, 1'b1, 32'hFFF0_F0F0, 1'b0);
        vec("and",  ALU_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 5'd11, 1'b0, 32'hF000_F000, 1'b0);
        vec("cpyb", ALU_COPY_B, 32'h1234_5678, 32'hCAFE_BABE, 5'd12, 1'b1, 32'hCAFE_BABE, 1'b0);
        vec("xxx",  ALU_XXX,    32'h1111_1111, 32'h2222_2222, 5'd5,  1'b1, 32'h0000_0000, 1'b1);
        vec("undB", 4'hB,       32'h3333_3333, 32'h4444_4444, 5'd13, 1'b0, 32'h0000_0000, 1'b1);
        in_valid = 1'b0;
        step();
        check_eq("drain_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure: A and B held, C waits, then all three in order.
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd10, 32'd1, 5'd20, 1'b1);
        step();
        check_eq("bp_a_valid", {31'd0, out_valid}, 32'd1);
        check_eq("bp_a_res",   out_result, 32'd11);
        check_eq("bp_a_inrdy", {31'd0, in_ready}, 32'd1);
        drive(ALU_ADD, 32'd20, 32'd2, 5'd21, 1'b1);
        step();
        check_eq("bp_b_inrdy", {31'd0, in_ready}, 32'd0);
        check_eq("bp_hold_a",  out_result, 32'd11);
        drive(ALU_ADD, 32'd30, 32'd3, 5'd22, 1'b1);
        step();
        check_eq("bp_c_inrdy", {31'd0, in_ready}, 32'd0);
        check_eq("bp_stable_res", out_result, 32'd11);
        check_eq("bp_stable_rd",  {27'd0, out_rd}, 32'd20);
        out_ready = 1'b1;
        step();
        check_eq("bp_out_b",   out_result, 32'd22);
        check_eq("bp_b_rd",    {27'd0, out_rd}, 32'd21);
        check_eq("bp_inrdy1",  {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("bp_out_c",   out_result, 32'd33);
        check_eq("bp_c_valid", {31'd0, out_valid}, 32'd1);
        step();
        check_eq("bp_done",    {31'd0, out_valid}, 32'd0);

        // Flush while TWO with a third op presented.
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd100, 32'd1, 5'd24, 1'b1);
        step();
        drive(ALU_ADD, 32'd200, 32'd2, 5'd25, 1'b1);
        step();
        check_eq("fl_two", {31'd0, in_ready}, 32'd0);
        drive(ALU_ADD, 32'd300, 32'd3, 5'd26, 1'b1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_valid", {31'd0, out_valid}, 32'd0);
        check_eq("fl_inrdy", {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("fl_gone", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset pulse while TWO.
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd7, 32'd1, 5'd27, 1'b1);
        step();
        drive(ALU_ADD, 32'd8, 32'd1, 5'd28, 1'b1);
        step();
        in_valid = 1'b0;
        check_eq("ar_two", {31'd0, in_ready}, 32'd0);
        reset_n = 1'b0;
        #1;
        check_eq("ar_valid", {31'd0, out_valid}, 32'd0);
        check_eq("ar_inrdy", {31'd0, in_ready},  32'd1);
        check_eq("ar_res",   out_result, 32'd0);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        check_eq("ar_idle", {31'd0, out_valid}, 32'd0);
        drive(ALU_ADD, 32'd2, 32'd3, 5'd29, 1'b0);
        step();
        in_valid = 1'b0;
        check_eq("ar_resume_v", {31'd0, out_valid}, 32'd1);
        check_eq("ar_resume_r", out_result, 32'd5);
        check_eq("ar_resume_rd", {27'd0, out_rd}, 32'd29);
        step();
        check_eq("ar_end", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
